// File: rtl/peak_pkg.sv
// Shared definitions for the peak window controller slice.
// Holds the controller state encoding, the default datapath widths and a
// small helper that sizes the hold-window counter.
package peak_pkg;

    localparam int DEF_BUS_WIDTH    = 6;
    localparam int DEF_CNT_WIDTH    = 9;
    localparam int DEF_HOLD_WINDOWS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACQ  = 1'b1
    } state_t;

    // Bits needed to count from HOLD_WINDOWS down to 0 (at least one bit).
    function automatic int hold_cnt_width(input int windows);
        return (windows < 1) ? 1 : $clog2(windows + 1);
    endfunction

endpackage

// File: rtl/peak_acc.sv
// Running-maximum register for one window of samples.
// Ports:
//   dclk      sample clock, posedge
//   rst       synchronous reset, active-low
//   clear     drop the partial window (register returns to 0)
//   sample_en a valid sample is being accumulated this cycle
//   restart   this sample is the first of a window: load it directly
//   din       unsigned sample
//   max_next  max including the current sample; the controller takes the
//             window result from here so the closing sample is included
module peak_acc
    import peak_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
    input  logic                 dclk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 sample_en,
    input  logic                 restart,
    input  logic [BUS_WIDTH-1:0] din,
    output logic [BUS_WIDTH-1:0] max_next
);

    logic [BUS_WIDTH-1:0] max_q;

    // Candidate max: a restart ignores whatever the previous window left behind.
    always_comb begin
        max_next = max_q;
        if (restart || (din > max_q)) begin
            max_next = din;
        end
    end

    // Running-max register.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            max_q <= '0;
        end else if (clear) begin
            max_q <= '0;
        end else if (sample_en) begin
            max_q <= max_next;
        end
    end

endmodule

// File: rtl/peak_window_ctrl.sv
// Windowed peak detector and peak-hold meter between the ADC deserialiser
// and the display driver. Every win_len+1 valid samples form one window;
// the window peak is offered on a valid/ready port, and a peak-hold level
// follows the window peaks with a timed decay.
// Ports:
//   dclk        sample clock, posedge
//   rst         synchronous reset, active-low
//   enable      1 = acquire windows, 0 = idle (partial window dropped)
//   win_len     window length minus 1, taken at each window start
//   din         unsigned sample
//   din_valid   din qualifier
//   peak_out    peak of the last completed window
//   peak_valid  peak_out pending for the consumer
//   peak_ready  consumer accepts peak_out
//   hold_level  peak-hold meter level
//   overrun     sticky flag: an unaccepted peak was overwritten
module peak_window_ctrl
    import peak_pkg::*;
#(
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int HOLD_WINDOWS = DEF_HOLD_WINDOWS
) (
    input  logic                 dclk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] win_len,
    input  logic [BUS_WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic [BUS_WIDTH-1:0] peak_out,
    output logic                 peak_valid,
    input  logic                 peak_ready,
    output logic [BUS_WIDTH-1:0] hold_level,
    output logic                 overrun
);

    localparam int HCW = hold_cnt_width(HOLD_WINDOWS);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_WINDOWS);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic [HCW-1:0]       hold_cnt_q;
    logic [BUS_WIDTH-1:0] win_max;
    logic                 sample;
    logic                 first;
    logic                 close;
    logic                 drop;

    // A sample only counts while acquiring and still enabled; the cycle that
    // drops enable discards the partial window instead of extending it.
    assign sample = (state_q == ST_ACQ) && enable && din_valid;
    assign first  = (count_q == '0);
    assign close  = sample && (count_q == len_q);
    assign drop   = (state_q == ST_ACQ) && !enable;

    peak_acc #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_acc (
        .dclk      (dclk),
        .rst       (rst),
        .clear     (drop),
        .sample_en (sample),
        .restart   (first),
        .din       (din),
        .max_next  (win_max)
    );

    // Next-state logic: enable alone moves between idle and acquisition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_ACQ;
            ST_ACQ:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample counter and latched window length. The length is taken when
    // acquisition starts and again on every close, so back-to-back windows
    // lose no samples.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            count_q <= '0;
            len_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            count_q <= '0;
            if (enable) begin
                len_q <= win_len;
            end
        end else if (drop) begin
            count_q <= '0;
        end else if (sample) begin
            if (close) begin
                count_q <= '0;
                len_q   <= win_len;
            end else begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output handshake. A close always wins: a simultaneous transfer just
    // means the old value was consumed, so only a close against a stalled
    // consumer counts as an overrun.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            peak_out   <= '0;
            peak_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (close) begin
            peak_out   <= win_max;
            peak_valid <= 1'b1;
            if (peak_valid && !peak_ready) begin
                overrun <= 1'b1;
            end
        end else if (peak_valid && peak_ready) begin
            peak_valid <= 1'b0;
        end
    end

    // Peak-hold meter: a new high (or equal) reloads the hold time; otherwise
    // the hold time runs out one window at a time before the level decays
    // by one step per window down to zero.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            hold_level <= '0;
            hold_cnt_q <= '0;
        end else if (close) begin
            if (win_max >= hold_level) begin
                hold_level <= win_max;
                hold_cnt_q <= HOLD_LOAD;
            end else if (hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - HCW'(1);
            end else if (hold_level != '0) begin
                hold_level <= hold_level - BUS_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_peak_window_ctrl.sv
// Self-checking bench for peak_window_ctrl: directed scenarios with
// hand-derived expectations, then a randomized run against a window/queue
// based reference model.
module tb_peak_window_ctrl;

    localparam int BW = 6;
    localparam int CW = 9;
    localparam int HW = 2;

    logic          dclk;
    logic          rst;
    logic          enable;
    logic [CW-1:0] win_len;
    logic [BW-1:0] din;
    logic          din_valid;
    logic [BW-1:0] peak_out;
    logic          peak_valid;
    logic          peak_ready;
    logic [BW-1:0] hold_level;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers and a sample queue).
    bit m_acq;
    int m_len;
    int m_win[$];
    int m_peak;
    bit m_pv;
    bit m_ovr;
    int m_hold;
    int m_hcnt;

    peak_window_ctrl #(
        .BUS_WIDTH    (BW),
        .CNT_WIDTH    (CW),
        .HOLD_WINDOWS (HW)
    ) dut (
        .dclk       (dclk),
        .rst        (rst),
        .enable     (enable),
        .win_len    (win_len),
        .din        (din),
        .din_valid  (din_valid),
        .peak_out   (peak_out),
        .peak_valid (peak_valid),
        .peak_ready (peak_ready),
        .hold_level (hold_level),
        .overrun    (overrun)
    );

    // Free-running sample clock.
    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic tick;
        @(posedge dclk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b0;
        enable    = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic start_acq(input int len);
        win_len   = CW'(len);
        enable    = 1'b1;
        din_valid = 1'b0;
        tick();
    endtask

    task automatic feed(input int value);
        din       = BW'(value);
        din_valid = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        peak_ready = 1'b1;
        win_len    = '0;
        do_reset();
        checks++;
        if ({peak_valid, peak_out, hold_level, overrun} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got pv=%0b peak=%0d hold=%0d ovr=%0b want all 0",
                     peak_valid, peak_out, hold_level, overrun);
        end
    endtask

    task automatic test_basic;
        do_reset();
        peak_ready = 1'b1;
        start_acq(3);
        feed(5); feed(9); feed(2);
        checks++;
        if (peak_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_early_valid got %0b want 0", peak_valid);
        end
        feed(7);
        checks++;
        if ({peak_valid, peak_out} !== {1'b1, 6'd9}) begin
            errors++;
            $display("[TB] FAIL basic_peak1 got pv=%0b peak=%0d want pv=1 peak=9", peak_valid, peak_out);
        end
        feed(1);
        checks++;
        if (peak_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_valid_drop got %0b want 0", peak_valid);
        end
        feed(1); feed(1); feed(1);
        checks++;
        if ({peak_valid, peak_out} !== {1'b1, 6'd1}) begin
            errors++;
            $display("[TB] FAIL basic_peak2 got pv=%0b peak=%0d want pv=1 peak=1", peak_valid, peak_out);
        end
        din_valid = 1'b0;
        tick();
        checks++;
        if ({peak_valid, hold_level, overrun} !== {1'b0, 6'd9, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_after got pv=%0b hold=%0d ovr=%0b want pv=0 hold=9 ovr=0",
                     peak_valid, hold_level, overrun);
        end
    endtask

    task automatic test_overrun;
        do_reset();
        peak_ready = 1'b0;
        start_acq(3);
        feed(9); feed(1); feed(1); feed(1);
        checks++;
        if ({peak_valid, peak_out, overrun} !== {1'b1, 6'd9, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ovr_first got pv=%0b peak=%0d ovr=%0b want 1 9 0", peak_valid, peak_out, overrun);
        end
        feed(12); feed(0); feed(0); feed(0);
        checks++;
        if ({peak_valid, peak_out, overrun, hold_level} !== {1'b1, 6'd12, 1'b1, 6'd12}) begin
            errors++;
            $display("[TB] FAIL ovr_second got pv=%0b peak=%0d ovr=%0b hold=%0d want 1 12 1 12",
                     peak_valid, peak_out, overrun, hold_level);
        end
        din_valid  = 1'b0;
        peak_ready = 1'b1;
        tick();
        checks++;
        if ({peak_valid, overrun} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ovr_accept got pv=%0b ovr=%0b want pv=0 ovr=1", peak_valid, overrun);
        end
    endtask

    task automatic test_back_to_back;
        // Close and transfer in the same cycle: no overrun, valid stays high.
        do_reset();
        peak_ready = 1'b1;
        start_acq(0);
        feed(20); feed(33);
        checks++;
        if ({peak_valid, peak_out, overrun} !== {1'b1, 6'd33, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b got pv=%0b peak=%0d ovr=%0b want 1 33 0", peak_valid, peak_out, overrun);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_sparse_valid;
        do_reset();
        peak_ready = 1'b1;
        start_acq(1);
        feed(3);
        din = 6'd63; din_valid = 1'b0; tick();
        feed(8);
        checks++;
        if ({peak_valid, peak_out} !== {1'b1, 6'd8}) begin
            errors++;
            $display("[TB] FAIL sparse_peak1 got pv=%0b peak=%0d want 1 8", peak_valid, peak_out);
        end
        din = 6'd63; din_valid = 1'b0; tick();
        checks++;
        if (peak_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sparse_drop got %0b want 0", peak_valid);
        end
        feed(4);
        din = 6'd63; din_valid = 1'b0; tick();
        feed(2);
        checks++;
        if ({peak_valid, peak_out} !== {1'b1, 6'd4}) begin
            errors++;
            $display("[TB] FAIL sparse_peak2 got pv=%0b peak=%0d want 1 4", peak_valid, peak_out);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_enable_drop;
        do_reset();
        peak_ready = 1'b1;
        start_acq(3);
        feed(30); feed(20);
        enable = 1'b0; din_valid = 1'b0; tick();
        checks++;
        if (peak_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_no_peak got %0b want 0", peak_valid);
        end
        start_acq(3);
        feed(6); feed(5);
        checks++;
        if (peak_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_stale_close got %0b want 0", peak_valid);
        end
        feed(4); feed(3);
        checks++;
        if ({peak_valid, peak_out} !== {1'b1, 6'd6}) begin
            errors++;
            $display("[TB] FAIL drop_peak got pv=%0b peak=%0d want 1 6", peak_valid, peak_out);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_hold;
        int peaks[5] = '{40, 10, 10, 10, 10};
        int holds[5] = '{40, 40, 40, 39, 38};
        do_reset();
        peak_ready = 1'b1;
        start_acq(0);
        for (int i = 0; i < 5; i++) begin
            feed(peaks[i]);
            checks++;
            if ({peak_out, hold_level} !== {BW'(peaks[i]), BW'(holds[i])}) begin
                errors++;
                $display("[TB] FAIL hold_step%0d got peak=%0d hold=%0d want peak=%0d hold=%0d",
                         i, peak_out, hold_level, peaks[i], holds[i]);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        peak_ready = 1'b0;
        start_acq(3);
        feed(9); feed(1); feed(1); feed(1);
        feed(2); feed(2); feed(2); feed(2);
        feed(5);
        checks++;
        if ({peak_valid, overrun} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rmid_setup got pv=%0b ovr=%0b want 1 1", peak_valid, overrun);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({peak_valid, peak_out, hold_level, overrun} !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_outputs got pv=%0b peak=%0d hold=%0d ovr=%0b want all 0",
                     peak_valid, peak_out, hold_level, overrun);
        end
        // Out of reset in IDLE: the first enabled cycle only starts acquisition.
        rst = 1'b1; peak_ready = 1'b1; win_len = '0;
        feed(50);
        checks++;
        if (peak_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_idle got %0b want 0", peak_valid);
        end
        feed(7);
        checks++;
        if ({peak_valid, peak_out} !== {1'b1, 6'd7}) begin
            errors++;
            $display("[TB] FAIL rmid_restart got pv=%0b peak=%0d want 1 7", peak_valid, peak_out);
        end
        din_valid = 1'b0;
    endtask

    task automatic model_reset;
        m_acq = 0; m_len = 0; m_win.delete();
        m_peak = 0; m_pv = 0; m_ovr = 0; m_hold = 0; m_hcnt = 0;
    endtask

    // One clock edge of the reference model, using the inputs seen at that edge.
    task automatic model_edge;
        bit closed;
        int r;
        closed = 0;
        r = 0;
        if (!rst) begin
            model_reset();
        end else begin
            if (!m_acq) begin
                if (enable) begin
                    m_acq = 1;
                    m_len = int'(win_len);
                end
            end else if (!enable) begin
                m_acq = 0;
                m_win.delete();
            end else if (din_valid) begin
                m_win.push_back(int'(din));
                if (m_win.size() == m_len + 1) begin
                    foreach (m_win[k]) if (m_win[k] > r) r = m_win[k];
                    closed = 1;
                    m_win.delete();
                    m_len = int'(win_len);
                end
            end
            if (closed) begin
                if (m_pv && !peak_ready) m_ovr = 1;
                m_peak = r;
                m_pv   = 1;
                if (r >= m_hold) begin
                    m_hold = r;
                    m_hcnt = HW;
                end else if (m_hcnt != 0) begin
                    m_hcnt--;
                end else if (m_hold > 0) begin
                    m_hold--;
                end
            end else if (m_pv && peak_ready) begin
                m_pv = 0;
            end
        end
    endtask

    task automatic test_random;
        int shown = 0;
        do_reset();
        model_reset();
        win_len = CW'(2);
        enable  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) win_len = CW'($urandom_range(0, 5));
            din        = BW'($urandom_range(0, 63));
            din_valid  = ($urandom_range(0, 3) != 0);
            peak_ready = ($urandom_range(0, 2) != 0);
            @(posedge dclk);
            model_edge();
            #1;
            checks++;
            if ({peak_valid, peak_out, overrun, hold_level} !==
                {m_pv, BW'(m_peak), m_ovr, BW'(m_hold)}) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("[TB] FAIL random_c%0d got pv=%0b peak=%0d ovr=%0b hold=%0d want pv=%0b peak=%0d ovr=%0b hold=%0d",
                             c, peak_valid, peak_out, overrun, hold_level, m_pv, m_peak, m_ovr, m_hold);
                end
            end
        end
        din_valid = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        rst        = 1'b0;
        enable     = 1'b0;
        win_len    = '0;
        din        = '0;
        din_valid  = 1'b0;
        peak_ready = 1'b1;
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_sparse_valid();
        test_enable_drop();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
